// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the iterative multiply/divide unit: operation codes,
// FSM state encoding and a helper that tells signed from unsigned operations.
// -----------------------------------------------------------------------------
package mdu_pkg;

    // Operation codes carried on the 3-bit op field; codes 6 and 7 are reserved.
    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } state_e;

    // Signed operations take operand magnitudes and need sign correction.
    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_if.sv
// -----------------------------------------------------------------------------
// mdu_if
// Issue/result bundle between the EX stage (master) and mdu_iter (slave).
//   start  : launch an operation (only honoured while busy=0)
//   op     : operation code, see mdu_pkg::op_e
//   rs_val : operand A / dividend / MTHI-MTLO data
//   rt_val : operand B / divisor
//   cancel : abort the in-flight operation on a pipeline flush
//   busy   : operation in flight, hazard logic stalls on it
//   done   : one-cycle pulse, HI/LO just written by a mult/div
//   hi, lo : architectural HI/LO registers
// -----------------------------------------------------------------------------
interface mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_val, rt_val, cancel,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, cancel,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_abs_neg.sv
// -----------------------------------------------------------------------------
// mdu_abs_neg
// Combinational conditional two's-complement negate. Used both to take operand
// magnitudes and to apply the final sign to products, quotients and remainders.
//   din  : value in
//   neg  : 1 = output -din, 0 = pass through
//   dout : result (same width; -MIN wraps to MIN, which as an unsigned value is
//          exactly the magnitude 2^(W-1))
// -----------------------------------------------------------------------------
module mdu_abs_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] din,
    input  logic         neg,
    output logic [W-1:0] dout
);
    assign dout = neg ? -din : din;
endmodule

// File: rtl/mdu_iter.sv
// -----------------------------------------------------------------------------
// mdu_iter
// Iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with HI/LO registers. Works on
// operand magnitudes one bit per cycle (radix-2 shift/add multiply, restoring
// divide), then applies the sign in a single FIX cycle that writes HI/LO.
//   clk : core clock
//   rst : synchronous active-high reset
//   bus : mdu_if slave modport (start/op/rs_val/rt_val/cancel in,
//         busy/done/hi/lo out)
// Latency of a mult/div is WIDTH+1 cycles from the start edge; busy is high for
// exactly that long and done pulses in the cycle after HI/LO are written.
// -----------------------------------------------------------------------------
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic   clk,
    input logic   rst,
    mdu_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;       // MUL: {partial, multiplier}; DIV: {remainder, dividend/quotient}
    logic [WIDTH-1:0]   b_q, b_d;           // multiplicand / divisor magnitude
    logic               is_mul_q, is_mul_d;
    logic               neg_lo_q, neg_lo_d; // negate product (MUL) or quotient (DIV)
    logic               neg_hi_q, neg_hi_d; // negate remainder (DIV only)
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    // ---------------------------------------------------------------- operands
    logic             a_neg, b_neg, rt_zero;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign a_neg   = is_signed_op(bus.op) & bus.rs_val[WIDTH-1];
    assign b_neg   = is_signed_op(bus.op) & bus.rt_val[WIDTH-1];
    assign rt_zero = (bus.rt_val == '0);

    mdu_abs_neg #(.W(WIDTH)) u_abs_a (.din(bus.rs_val), .neg(a_neg), .dout(a_mag));
    mdu_abs_neg #(.W(WIDTH)) u_abs_b (.din(bus.rt_val), .neg(b_neg), .dout(b_mag));

    // --------------------------------------------------------- result fix-up
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    mdu_abs_neg #(.W(2*WIDTH)) u_fix_prod (.din(acc_q),              .neg(neg_lo_q), .dout(prod_fix));
    mdu_abs_neg #(.W(WIDTH))   u_fix_quo  (.din(acc_q[WIDTH-1:0]),   .neg(neg_lo_q), .dout(quo_fix));
    mdu_abs_neg #(.W(WIDTH))   u_fix_rem  (.din(acc_q[2*WIDTH-1:WIDTH]), .neg(neg_hi_q), .dout(rem_fix));

    // ------------------------------------------------------------ iterations
    // Multiply: add multiplicand into the upper half when the multiplier LSB
    // is set, then shift the whole accumulator right; the carry enters at top.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide: shift the next dividend bit into the remainder, keep
    // the difference only if it did not go negative; that decision is the
    // quotient bit shifted in at the bottom. A zero divisor naturally yields
    // an all-ones quotient and the dividend as remainder.
    logic [WIDTH:0]     div_top, div_diff;
    logic               div_ok;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;

    assign div_top  = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff = div_top - {1'b0, b_q};
    assign div_ok   = (div_top >= {1'b0, b_q});
    assign div_rem  = div_ok ? div_diff[WIDTH-1:0] : div_top[WIDTH-1:0];
    assign div_next = {div_rem, acc_q[WIDTH-2:0], div_ok};

    // ------------------------------------------------------ next-state logic
    always_comb begin
        // NOTE: every signal gets its hold value first so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        b_d      = b_q;
        is_mul_d = is_mul_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.cancel) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: begin
                            state_d  = MUL;
                            cnt_d    = '0;
                            acc_d    = {{WIDTH{1'b0}}, a_mag};
                            b_d      = b_mag;
                            is_mul_d = 1'b1;
                            neg_lo_d = a_neg ^ b_neg;
                            neg_hi_d = 1'b0;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d  = DIV;
                            cnt_d    = '0;
                            acc_d    = {{WIDTH{1'b0}}, a_mag};
                            b_d      = b_mag;
                            is_mul_d = 1'b0;
                            // A zero divisor must leave the all-ones quotient untouched.
                            neg_lo_d = (a_neg ^ b_neg) & ~rt_zero;
                            neg_hi_d = a_neg;
                        end
                        OP_MTHI: hi_d = bus.rs_val;
                        OP_MTLO: lo_d = bus.rs_val;
                        default: ; // reserved codes are ignored
                    endcase
                end
            end
            MUL, DIV: begin
                if (bus.cancel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_d = (state_q == MUL) ? mul_next : div_next;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = FIX;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!bus.cancel) begin
                    done_d = 1'b1;
                    if (is_mul_q) begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------- registers
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // NOTE: datapath registers are always loaded at start before use, so they carry no reset.
    always_ff @(posedge clk) begin
        acc_q    <= acc_d;
        b_q      <= b_d;
        is_mul_q <= is_mul_d;
        neg_lo_q <= neg_lo_d;
        neg_hi_q <= neg_hi_d;
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
